// File: rtl/stage4_resolve_unit.sv
// Final pipeline stage control: owns the flag register, resolves branches,
// drives register-file write strobes and squashes wrong-path work.
module stage4_resolve_unit #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] opcode,
  input  logic       E_R0,
  input  logic       E_RN,
  input  logic       XR0,
  input  logic       SOD,
  input  logic       EFL,
  input  logic       BB3,
  input  logic       S_AL,
  input  logic       LPC,
  input  logic [3:0] alu_flags,
  output logic [3:0] flags,
  output logic       wr_r0,
  output logic       wr_rn,
  output logic [1:0] wb_sel,
  output logic       pc_load,
  output logic       flush,
  output logic       hold_release
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;
  logic       wr_r0_q, wr_r0_d;
  logic       wr_rn_q, wr_rn_d;
  logic [1:0] wb_sel_q, wb_sel_d;
  logic       pc_load_q, pc_load_d;
  logic       hold_q, hold_d;
  logic       cond_true;
  logic       taken;
  logic       unused_opcode;

  // <fl> field: bits [1:0] pick C/Z/S/P, bit 2 is the polarity (1 = branch if set).
  function automatic logic cond_eval(input logic [3:0] f, input logic [2:0] fl);
    logic bit_sel;
    case (fl[1:0])
      2'd0:    bit_sel = f[3];
      2'd1:    bit_sel = f[2];
      2'd2:    bit_sel = f[1];
      default: bit_sel = f[0];
    endcase
    return ~(bit_sel ^ fl[2]);
  endfunction

  // No writeback means source select is parked at 00.
  function automatic logic [1:0] wb_select(input logic any_wr, input logic s_al,
                                           input logic sod);
    if (!any_wr)   return 2'b00;
    else if (s_al) return 2'b00;
    else if (sod)  return 2'b01;
    else           return 2'b10;
  endfunction

  assign unused_opcode = ^opcode[7:3];
  assign cond_true     = cond_eval(flags_q, opcode[2:0]);
  assign taken         = LPC & (~EFL | cond_true);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flags_d   = flags_q;
    wr_r0_d   = 1'b0;
    wr_rn_d   = 1'b0;
    wb_sel_d  = 2'b00;
    pc_load_d = 1'b0;
    hold_d    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (S_AL) flags_d = alu_flags;
        wr_r0_d   = E_R0 | XR0;
        wr_rn_d   = E_RN;
        wb_sel_d  = wb_select(E_R0 | XR0 | E_RN, S_AL, SOD);
        pc_load_d = taken;
        // Any resolved conditional releases stage 1, taken or not.
        hold_d    = EFL & BB3;
        if (taken) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_INIT;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 2'd0) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= 2'd0;
      flags_q   <= 4'b0000;
      wr_r0_q   <= 1'b0;
      wr_rn_q   <= 1'b0;
      wb_sel_q  <= 2'b00;
      pc_load_q <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flags_q   <= flags_d;
      wr_r0_q   <= wr_r0_d;
      wr_rn_q   <= wr_rn_d;
      wb_sel_q  <= wb_sel_d;
      pc_load_q <= pc_load_d;
      hold_q    <= hold_d;
    end
  end

  assign flags        = flags_q;
  assign wr_r0        = wr_r0_q;
  assign wr_rn        = wr_rn_q;
  assign wb_sel       = wb_sel_q;
  assign pc_load      = pc_load_q;
  assign flush        = (state_q == ST_FLUSH);
  assign hold_release = hold_q;

endmodule

// File: tb/tb_stage4_resolve_unit.sv
// Bench for stage4_resolve_unit: directed vector table, reset corners and a
// randomized run against a cycle-level behavioural model.
module tb_stage4_resolve_unit;

  localparam int FC = 2;

  localparam logic [7:0] C_ER0 = 8'h80;
  localparam logic [7:0] C_ERN = 8'h40;
  localparam logic [7:0] C_XR0 = 8'h20;
  localparam logic [7:0] C_SOD = 8'h10;
  localparam logic [7:0] C_EFL = 8'h08;
  localparam logic [7:0] C_BB3 = 8'h04;
  localparam logic [7:0] C_SAL = 8'h02;
  localparam logic [7:0] C_LPC = 8'h01;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] op = 8'h00;
  logic [7:0] ctl = 8'h00;
  logic [3:0] af = 4'h0;

  logic [3:0] flags;
  logic       wr_r0, wr_rn, pc_load, flush, hold_release;
  logic [1:0] wb_sel;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] m_flags;
  int         m_squash;
  logic [10:0] m_exp;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  ctl;
    logic [3:0]  af;
    logic [10:0] exp;
  } vec_t;

  vec_t vt[16];

  always #5 clk = ~clk;

  stage4_resolve_unit #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(op),
    .E_R0(ctl[7]), .E_RN(ctl[6]), .XR0(ctl[5]), .SOD(ctl[4]),
    .EFL(ctl[3]), .BB3(ctl[2]), .S_AL(ctl[1]), .LPC(ctl[0]),
    .alu_flags(af), .flags(flags), .wr_r0(wr_r0), .wr_rn(wr_rn),
    .wb_sel(wb_sel), .pc_load(pc_load), .flush(flush), .hold_release(hold_release)
  );

  // Packed view: {flags, wr_r0, wr_rn, wb_sel, pc_load, flush, hold_release}
  function automatic logic [10:0] mk(input logic [3:0] f, input logic r0, input logic rn,
                                     input logic [1:0] wb, input logic pc,
                                     input logic fl, input logic hr);
    return {f, r0, rn, wb, pc, fl, hr};
  endfunction

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] act;
    act = {flags, wr_r0, wr_rn, wb_sel, pc_load, flush, hold_release};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b ({flags,r0,rn,wb,pc,flush,hr})", name, act, exp);
    end
  endtask

  // Behavioural model: one call per clock using the inputs about to be sampled.
  task automatic model_step();
    int   idx;
    logic cond, tk, w0, wn, hr;
    logic [1:0] wb;
    if (m_squash > 0) begin
      m_squash = m_squash - 1;
      m_exp = mk(m_flags, 1'b0, 1'b0, 2'b00, 1'b0, m_squash > 0, 1'b0);
    end else begin
      idx  = 3 - int'(op[1:0]);
      cond = (m_flags[idx] == op[2]);
      tk   = ctl[0] && (!ctl[3] || cond);
      w0   = ctl[7] || ctl[5];
      wn   = ctl[6];
      if (!(w0 || wn))  wb = 2'b00;
      else if (ctl[1])  wb = 2'b00;
      else if (ctl[4])  wb = 2'b01;
      else              wb = 2'b10;
      hr = ctl[3] && ctl[2];
      if (ctl[1]) m_flags = af;
      m_exp = mk(m_flags, w0, wn, wb, tk, tk, hr);
      if (tk) m_squash = FC;
    end
  endtask

  initial begin
    vt[0]  = '{8'h80, C_SAL | C_ER0,         4'b0100, mk(4'b0100, 1, 0, 2'b00, 0, 0, 0)};
    vt[1]  = '{8'h0D, C_EFL | C_LPC | C_BB3, 4'b0000, mk(4'b0100, 0, 0, 2'b00, 1, 1, 1)};
    vt[2]  = '{8'h80, C_SAL | C_ER0,         4'b1111, mk(4'b0100, 0, 0, 2'b00, 0, 1, 0)};
    vt[3]  = '{8'h80, C_SAL | C_ER0,         4'b1111, mk(4'b0100, 0, 0, 2'b00, 0, 0, 0)};
    vt[4]  = '{8'h80, C_SAL | C_ER0,         4'b0000, mk(4'b0000, 1, 0, 2'b00, 0, 0, 0)};
    vt[5]  = '{8'h0D, C_EFL | C_LPC | C_BB3, 4'b0000, mk(4'b0000, 0, 0, 2'b00, 0, 0, 1)};
    vt[6]  = '{8'h28, C_EFL | C_LPC,         4'b0000, mk(4'b0000, 0, 0, 2'b00, 1, 1, 0)};
    vt[7]  = '{8'h00, 8'h00,                 4'b0000, mk(4'b0000, 0, 0, 2'b00, 0, 1, 0)};
    vt[8]  = '{8'h00, 8'h00,                 4'b0000, mk(4'b0000, 0, 0, 2'b00, 0, 0, 0)};
    vt[9]  = '{8'h00, C_SOD | C_ERN,         4'b1111, mk(4'b0000, 0, 1, 2'b01, 0, 0, 0)};
    vt[10] = '{8'h00, C_XR0,                 4'b1111, mk(4'b0000, 1, 0, 2'b10, 0, 0, 0)};
    vt[11] = '{8'h00, C_LPC | C_BB3,         4'b0000, mk(4'b0000, 0, 0, 2'b00, 1, 1, 0)};
    vt[12] = '{8'h09, C_EFL | C_LPC | C_BB3, 4'b0000, mk(4'b0000, 0, 0, 2'b00, 0, 1, 0)};
    vt[13] = '{8'h00, 8'h00,                 4'b0000, mk(4'b0000, 0, 0, 2'b00, 0, 0, 0)};
    vt[14] = '{8'h80, C_SAL | C_SOD | C_ERN, 4'b1010, mk(4'b1010, 0, 1, 2'b00, 0, 0, 0)};
    vt[15] = '{8'h0C, C_EFL | C_LPC,         4'b0000, mk(4'b1010, 0, 0, 2'b00, 1, 1, 0)};

    // Power-up reset with random inputs.
    op = 8'($urandom); ctl = 8'($urandom); af = 4'($urandom);
    #12;
    check("reset_initial", 11'd0);
    #8;
    rst_n = 1'b1;

    foreach (vt[i]) begin
      op = vt[i].op; ctl = vt[i].ctl; af = vt[i].af;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vt[i].exp);
    end

    // Asynchronous reset in the middle of the flush window.
    op = 8'($urandom); ctl = 8'($urandom); af = 4'($urandom);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_async_midflush", 11'd0);
    @(posedge clk); #1;
    check("reset_held", 11'd0);
    op = 8'h80; ctl = C_SAL | C_ER0; af = 4'b0110;
    #3;
    rst_n = 1'b1;
    #1;
    check("release_before_edge", 11'd0);
    @(posedge clk); #1;
    check("release_first_wb", mk(4'b0110, 1, 0, 2'b00, 0, 0, 0));

    // Randomized run against the model.
    m_flags  = 4'b0110;
    m_squash = 0;
    for (int k = 0; k < 400; k++) begin
      op  = 8'($urandom);
      ctl = 8'($urandom);
      af  = 4'($urandom);
      if ($urandom_range(0, 3) != 0) ctl[0] = 1'b0;
      model_step();
      @(posedge clk); #1;
      check($sformatf("rand%0d", k), m_exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stage4_resolve_unit.md
# stage4_resolve_unit

Fourth (final) pipeline stage control block of the RISC pipeline. It consumes the registered control word from the stage-3 control code generator: E_R0, E_RN, XR0, SOD, EFL, BB3, S_AL, LPC and the stage-3 opcode. It owns the processor flag register, resolves conditional branches, produces the register-file write strobes and the writeback source select, and squashes wrong-path instructions after a taken branch.

## Interface
- FLUSH_CYCLES, 2, squash length after a taken branch, in cycles (legal 1..3).
- clk  in  1  system-wide clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  8  stage-3 opcode; opcode[2:0] is the <fl> field for conditional ops.
- E_R0, E_RN, XR0, SOD  in  1 each  pass-through enables from stage 3.
- EFL  in  1  evaluate flags (conditional op).
- BB3  in  1  stage 1 currently held by a conditional op.
- S_AL  in  1  ALU result goes to stage 4; flags update.
- LPC  in  1  PC load request.
- alu_flags  in  4  {C,Z,S,P} from the ALU for the current op.
- flags  out  4  architectural flag register {C,Z,S,P}.
- wr_r0  out  1  R0 write strobe.
- wr_rn  out  1  Rn write strobe.
- wb_sel  out  2  00 ALU, 01 operand (OD), 10 data bus, 11 unused.
- pc_load  out  1  one-cycle PC load strobe.
- flush  out  1  squash stages 1-3.
- hold_release  out  1  one-cycle pulse releasing the stage-1 hold.

## Operation
- Condition: sel=opcode[1:0] picks C/Z/S/P from the current flags register; pol=opcode[2]; cond_true = flag XNOR pol (pol=1 means branch if set).
- Evaluated against flags *before* this cycle's update; flag-writing op in the same cycle as EFL is impossible by encoding, so no forwarding.
- taken = LPC & (~EFL | cond_true).
- Flag register: loads alu_flags when S_AL=1 and state is RUN; otherwise holds.
- wr_r0 = E_R0 | XR0; wr_rn = E_RN; wb_sel = S_AL ? 00 : SOD ? 01 : 10. All are forced to 0/00 when squashing.
- States: RUN, FLUSH.
  - RUN: if taken, go to FLUSH, load a counter with FLUSH_CYCLES-1, and pulse pc_load.
  - RUN: if EFL & BB3 & ~taken, pulse hold_release and stay in RUN.
  - FLUSH: flush=1; inputs ignored (no flag update, no writes, no branch evaluation). When the counter reaches 0, return to RUN; otherwise decrement.
- Taken conditional branch with BB3=1 also pulses hold_release in the same cycle as pc_load, so stage 1 restarts from the new PC.

## Timing
- Inputs sampled at rising edge N; all outputs are registered and valid after edge N. Latency is 1 cycle.
- pc_load and hold_release are exactly one cycle wide.
- flush is high for exactly FLUSH_CYCLES cycles, starting the cycle after the taken branch is sampled.
- Reset values: flags=0000, wr_r0=0, wr_rn=0, wb_sel=00, pc_load=0, flush=0, hold_release=0, state=RUN, counter=0.
- Reset mid-FLUSH aborts the flush immediately; flag state is not preserved.
- A branch back-to-back with a taken branch: the second branch lands in the FLUSH window and is ignored by design.
- wb_sel is a don't-care to the consumer when both write strobes are 0, but must still be 00 in that case.

## Test plan
- Reset: hold rst_n=0 mid-clock with random inputs -> all outputs and flags 0 asynchronously. Release -> first writeback obeys the 1-cycle latency.
- ALU op (opcode 8'h80, S_AL=1, E_R0=1, alu_flags=4'b0100) -> next cycle flags=0100, wr_r0=1, wb_sel=00.
- Taken branch: flags Z=1, opcode 8'h0D (JCD, sel=Z, pol=1), EFL=1, LPC=1, BB3=1 -> pc_load=1 and hold_release=1 for 1 cycle. Then flush=1 for 2 cycles, during which an ALU op with S_AL=1 leaves flags unchanged and wr_r0=0.
- Not-taken branch: same as above with Z=0 -> pc_load=0, flush=0, hold_release=1 for 1 cycle.
- Negative polarity: C=0, opcode 8'h28 (JCA, sel=C, pol=0), EFL=1, LPC=1 -> taken, pc_load=1.
- MVI-style writeback (SOD=1, E_RN=1, S_AL=0) -> wr_rn=1, wb_sel=01, flags unchanged.
- Load from bus (XR0=1, S_AL=0, SOD=0) -> wr_r0=1, wb_sel=10.
